// File: rtl/hex_display_arbiter_if.sv
// Handshake and display bus shared by two requesters and the display arbiter.
// The requester side drives req/data and watches the grants. The arbiter side
// drives the grants and the registered digit outputs.
interface hex_display_arbiter_if;
  logic        req0;
  logic [15:0] data0;
  logic        req1;
  logic [15:0] data1;
  logic        gnt0;
  logic        gnt1;
  logic [15:0] hex_nibbles;
  logic [3:0]  blank;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, hex_nibbles, blank
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, hex_nibbles, blank
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Two-requester arbiter for a shared four-digit seven-segment display.
//
// A requester owns the display while its req is held. When both requesters
// contend, ownership alternates after the owner has held the display for
// DWELL cycles. The owner's live value is registered onto hex_nibbles
// together with a per-digit blank mask that can hide leading zeros. Digit 0
// always shows, so a value of zero still displays a single "0".
//
// Every output comes straight from a register, so no input reaches an
// output combinationally.
module hex_display_arbiter #(
  parameter int unsigned DWELL    = 50_000_000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  hex_display_arbiter_if.slave  bus
);

  // The dwell counter only has to reach DWELL-1. It keeps one bit when
  // DWELL is 1, because a zero-width vector is not legal.
  localparam int unsigned     CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   DWELL_MAX = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW0 = 2'd1,
    SHOW1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic            last_q,  last_d;   // most recently granted requester
  logic [15:0]     hex_q,   hex_d;
  logic [3:0]      blank_q, blank_d;

  logic            entering;          // next state is a SHOW state that differs from the current one
  logic [15:0]     owner_data;

  // Build the blank mask for leading zeros. A digit is blanked only when it
  // and every digit to its left are zero. Digit 0 is never blanked.
  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'h0);
    m[2] = m[3] & (d[11:8] == 4'h0);
    m[1] = m[2] & (d[7:4]  == 4'h0);
    m[0] = 1'b0;
    if (!LZ_BLANK) m = 4'h0;
    return m;
  endfunction

  // Ownership decision: grant on request, release on drop, rotate on dwell expiry.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? SHOW0 : SHOW1;
        else if (bus.req0)        state_d = SHOW0;
        else if (bus.req1)        state_d = SHOW1;
      end
      SHOW0: begin
        // A drop takes priority over dwell expiry on the same edge.
        if (!bus.req0)                            state_d = bus.req1 ? SHOW1 : IDLE;
        else if (bus.req1 && dwell_q == DWELL_MAX) state_d = SHOW1;
      end
      SHOW1: begin
        if (!bus.req1)                            state_d = bus.req0 ? SHOW0 : IDLE;
        else if (bus.req0 && dwell_q == DWELL_MAX) state_d = SHOW0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Dwell counter, last-served tracking and display data, all derived from
  // the next state.
  always_comb begin
    entering   = (state_d != IDLE) && (state_d != state_q);
    owner_data = (state_d == SHOW1) ? bus.data1 : bus.data0;
    dwell_d    = dwell_q;
    last_d     = last_q;
    hex_d      = 16'h0000;
    blank_d    = 4'hF;

    if (state_d == IDLE) begin
      dwell_d = '0;
    end else begin
      hex_d   = owner_data;
      blank_d = lz_mask(owner_data);
      if (entering) begin
        dwell_d = '0;
        last_d  = (state_d == SHOW1);
      end else if (dwell_q != DWELL_MAX) begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // State and output registers. Reset clears them asynchronously.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      dwell_q <= '0;
      last_q  <= 1'b1;            // requester 0 wins the first tie
      hex_q   <= 16'h0000;
      blank_q <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments let all registers update together
      // from values sampled before the edge.
      state_q <= state_d;
      dwell_q <= dwell_d;
      last_q  <= last_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
    end
  end

  // The grants are decoded directly from the state register.
  assign bus.gnt0        = (state_q == SHOW0);
  assign bus.gnt1        = (state_q == SHOW1);
  assign bus.hex_nibbles = hex_q;
  assign bus.blank       = blank_q;

endmodule
